if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameters SHALL be: WORD_BITWIDTH, 32, datapath width; RESET_PC, 32'h0000_0000, first fetch address; NOP_INSN, 32'h0000_0013, bubble encoding.
REQ-002 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, reset; asynchronous and active-low (asserted at 0).
REQ-004 Port hz_write, input, 1, hazard hold from the decode side; 1 means the IF/ID register holds, so this block must not advance its output.
REQ-005 Port redirect, input, 1, taken branch or jump; flush and restart fetch at redirect_pc.
REQ-006 Port redirect_pc, input, WORD_BITWIDTH, new fetch target.
REQ-007 Port imem_req_valid, output, 1, fetch request to instruction memory.
REQ-008 Port imem_req_ready, input, 1, memory accepts the request this cycle.
REQ-009 Port imem_addr, output, WORD_BITWIDTH, request address; equals fetch_pc.
REQ-010 Port imem_rsp_valid, input, 1, read data valid; one response per accepted request, in order.
REQ-011 Port imem_rsp_data, input, WORD_BITWIDTH, instruction word.
REQ-012 Port pc, output, WORD_BITWIDTH, registered PC presented to the IF/ID register.
REQ-013 Port instruction, output, WORD_BITWIDTH, registered instruction presented to the IF/ID register.
REQ-014 Port fetch_valid, output, 1, registered; 1 when pc/instruction hold a real fetched instruction, 0 for a bubble.

Function
REQ-015 The block SHALL have an internal fetch_pc register and a 4-state FSM: REQ, WAIT, HOLD, DROP.
REQ-016 At most one request SHALL be outstanding.
REQ-017 imem_req_valid SHALL be 1 only in REQ.
REQ-018 REQ: on imem_req_ready=1, go to WAIT; otherwise stay in REQ with imem_req_valid held.
REQ-019 WAIT, rsp_valid=1, hz_write=0: outputs SHALL update to pc=fetch_pc, instruction=imem_rsp_data, fetch_valid=1; fetch_pc += 4; go to REQ.
REQ-020 WAIT, rsp_valid=1, hz_write=1: rsp_data SHALL be captured into a hold buffer; go to HOLD; outputs unchanged.
REQ-021 HOLD: when hz_write=0, present the buffered word at fetch_pc (fetch_valid=1); fetch_pc += 4; go to REQ.
REQ-022 DROP: the next rsp_valid SHALL be discarded; go to REQ.
REQ-023 In any cycle with hz_write=1 and redirect=0, pc, instruction and fetch_valid SHALL hold their values.
REQ-024 In any cycle with hz_write=0 and no instruction delivered, outputs SHALL become the bubble: pc unchanged, instruction=NOP_INSN, fetch_valid=0.
REQ-025 redirect=1 SHALL override hz_write and every FSM action.
REQ-026 On redirect, fetch_pc <= {redirect_pc[W-1:2], 2'b00}, and the outputs SHALL become the bubble.
REQ-027 Redirect next state:
- REQ with request accepted this cycle: DROP.
- REQ not accepted: REQ, with the new address presented next cycle.
- WAIT with no response this cycle: DROP.
- WAIT with a response this cycle: REQ, response discarded.
- HOLD: REQ, buffer discarded.
- DROP with no response this cycle: stay in DROP.
- DROP with a response this cycle: REQ.
REQ-028 fetch_pc arithmetic SHALL be modulo 2^WORD_BITWIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-029 Minimum delivery latency SHALL be 2 cycles from request acceptance (accept, respond, register); peak throughput 1 instruction per 2 cycles.

Reset
REQ-030 On rst=0, the block SHALL asynchronously set: state=REQ, fetch_pc=RESET_PC, pc=0, instruction=NOP_INSN, fetch_valid=0, hold buffer=0.
REQ-031 A response arriving after reset release for a request issued before reset is forbidden by the memory contract; the block need not filter it.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction; after release, the first request SHALL be at RESET_PC.

Structure
REQ-033 The FSM state encoding, NOP_INSN and the PC increment constant (4) SHALL live in the shared pipeline package, alongside the IF/ID register widths.
REQ-034 The block SHALL be a single module with no sub-modules; the hold buffer and output registers are inline.

Verification
REQ-035 Reset release, memory always ready, 1-cycle response, hz_write=0 -> outputs (pc, fetch_valid) follow (0,1), bubble, (4,1), bubble, (8,1); instruction matches memory at each PC.
REQ-036 hz_write=1 for 3 cycles while the response for PC 0x10 arrives -> outputs frozen for 3 cycles; the word for 0x10 appears on the cycle after hz_write falls; no further request is issued during the hold.
REQ-037 redirect to 0x200 while WAIT for 0x14 -> bubble output; the late 0x14 response is dropped; next request address 0x200; first valid output pc=0x200.
REQ-038 redirect to 0x103 with hz_write=1 simultaneously -> redirect wins; outputs become the bubble; the next request address is 0x100.
REQ-039 fetch_pc=0xFFFF_FFFC delivered -> next imem_addr=0x0000_0000.
REQ-040 rst pulsed low while in HOLD -> outputs asynchronously become pc=0, NOP_INSN, fetch_valid=0; after release, the first request is at RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared pipeline constants and the fetch FSM state type.
package if_fetch_pkg;

  localparam int unsigned DEF_WORD_W   = 32;
  localparam int unsigned IFID_PC_W    = DEF_WORD_W;
  localparam int unsigned IFID_INSN_W  = DEF_WORD_W;
  localparam int unsigned PC_INC       = 4;
  localparam logic [IFID_INSN_W-1:0] DEF_NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_if
  import if_fetch_pkg::*;
#(
  parameter int unsigned W = IFID_PC_W
);

  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, hazard hold buffer,
// redirect flush with late-response drop, registered IF/ID outputs.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned              WORD_BITWIDTH = DEF_WORD_W,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = '0,
  parameter logic [WORD_BITWIDTH-1:0] NOP_INSN      = WORD_BITWIDTH'(DEF_NOP_INSN)
) (
  input  logic                     clk,
  input  logic                     rst,
  if_fetch_if.master               imem,
  input  logic                     hz_write,
  input  logic                     redirect,
  input  logic [WORD_BITWIDTH-1:0] redirect_pc,
  output logic [WORD_BITWIDTH-1:0] pc,
  output logic [WORD_BITWIDTH-1:0] instruction,
  output logic                     fetch_valid
);

  localparam logic [WORD_BITWIDTH-1:0] ALIGN_MASK = ~WORD_BITWIDTH'(3);

  fetch_state_e             state_q, state_d;
  logic [WORD_BITWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_BITWIDTH-1:0] pc_q, pc_d;
  logic [WORD_BITWIDTH-1:0] insn_q, insn_d;
  logic                     valid_q, valid_d;
  logic [WORD_BITWIDTH-1:0] hold_q, hold_d;
  logic                     req_valid_q;
  logic                     accepted;

  assign accepted = imem.imem_req_valid && imem.imem_req_ready;

  // Next-state and IF/ID output logic; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    valid_d    = valid_q;
    hold_d     = hold_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      insn_d     = NOP_INSN;
      valid_d    = 1'b0;
      case (state_q)
        ST_REQ:  state_d = accepted ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem.imem_rsp_valid ? ST_REQ : ST_DROP;
        ST_HOLD: state_d = ST_REQ;
        ST_DROP: state_d = imem.imem_rsp_valid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      // Bubble unless a delivery below overrides it; hz_write freezes outputs.
      if (!hz_write) begin
        insn_d  = NOP_INSN;
        valid_d = 1'b0;
      end
      case (state_q)
        ST_REQ: begin
          if (accepted) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem.imem_rsp_valid) begin
            if (hz_write) begin
              hold_d  = imem.imem_rsp_data;
              state_d = ST_HOLD;
            end else begin
              pc_d       = fetch_pc_q;
              insn_d     = imem.imem_rsp_data;
              valid_d    = 1'b1;
              fetch_pc_d = fetch_pc_q + WORD_BITWIDTH'(PC_INC);
              state_d    = ST_REQ;
            end
          end
        end
        ST_HOLD: begin
          if (!hz_write) begin
            pc_d       = fetch_pc_q;
            insn_d     = hold_q;
            valid_d    = 1'b1;
            fetch_pc_d = fetch_pc_q + WORD_BITWIDTH'(PC_INC);
            state_d    = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem.imem_rsp_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_REQ;
      fetch_pc_q  <= RESET_PC;
      pc_q        <= '0;
      insn_q      <= NOP_INSN;
      valid_q     <= 1'b0;
      hold_q      <= '0;
      req_valid_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      insn_q      <= insn_d;
      valid_q     <= valid_d;
      hold_q      <= hold_d;
      req_valid_q <= (state_d == ST_REQ);
    end
  end

  assign imem.imem_req_valid = req_valid_q;
  assign imem.imem_addr      = fetch_pc_q;
  assign pc                  = pc_q;
  assign instruction         = insn_q;
  assign fetch_valid         = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, corner sequences,
// and a randomized run against a stream-level reference model.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hz_write = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        fetch_valid;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  if_fetch_if #(.W(32)) bus ();

  if_fetch #(
    .WORD_BITWIDTH(32),
    .RESET_PC     (32'h0000_0000),
    .NOP_INSN     (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (bus),
    .hz_write   (hz_write),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .instruction(instruction),
    .fetch_valid(fetch_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F00;
  endfunction

  // Instruction memory: configurable response latency, optional random ready.
  int          lat_cfg    = 0;
  bit          rand_ready = 1'b0;
  logic        busy;
  int          cnt;
  logic [31:0] paddr;
  int          outstanding;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_rsp_data  <= '0;
      bus.imem_req_ready <= 1'b1;
      busy               <= 1'b0;
      cnt                <= 0;
      paddr              <= '0;
      outstanding        <= 0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      bus.imem_req_ready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      outstanding <= outstanding + ((bus.imem_req_valid && bus.imem_req_ready) ? 1 : 0)
                                 - (bus.imem_rsp_valid ? 1 : 0);
      if (busy) begin
        if (cnt == 0) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(paddr);
          busy               <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (lat_cfg == 0) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(bus.imem_addr);
        end else begin
          busy  <= 1'b1;
          cnt   <= lat_cfg - 1;
          paddr <= bus.imem_addr;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic h, input logic r, input logic [31:0] rp);
    hz_write    = h;
    redirect    = r;
    redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] p,
                            input logic rq, input logic [31:0] a);
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(v));
    chk({tag, ".pc"}, pc, p);
    chk({tag, ".instruction"}, instruction, v ? mem_word(p) : NOP);
    chk({tag, ".req_valid"}, 32'(bus.imem_req_valid), 32'(rq));
    chk({tag, ".imem_addr"}, bus.imem_addr, a);
  endtask

  typedef struct {
    logic        hz;
    logic        v;
    logic [31:0] p;
    logic        rq;
    logic [31:0] a;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic        h, r;
    logic [31:0] rp, exp_pc, prev_pc, prev_insn;
    logic        prev_valid;
    int          stall, deliveries;

    // Sequential fetch then a 3-cycle hazard hold over the 0x10 response.
    tbl[0]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h04 - 32'h04};
    tbl[1]  = '{1'b0, 1'b1, 32'h00, 1'b1, 32'h04};
    tbl[2]  = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h04};
    tbl[3]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h08};
    tbl[4]  = '{1'b0, 1'b0, 32'h04, 1'b0, 32'h08};
    tbl[5]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0C};
    tbl[6]  = '{1'b0, 1'b0, 32'h08, 1'b0, 32'h0C};
    tbl[7]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h10};
    tbl[8]  = '{1'b0, 1'b0, 32'h0C, 1'b0, 32'h10};
    tbl[9]  = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h10};
    tbl[10] = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h10};
    tbl[11] = '{1'b1, 1'b0, 32'h0C, 1'b0, 32'h10};
    tbl[12] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h14};

    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 32'h0, 1'b1, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].hz, 1'b0, 32'h0);
      expect_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].p, tbl[i].rq, tbl[i].a);
    end

    // Redirect to 0x200 while waiting on a late 0x14 response.
    lat_cfg = 1;
    step(1'b0, 1'b0, 32'h0);   expect_out("rd200.acc",  1'b0, 32'h10, 1'b0, 32'h14);
    step(1'b0, 1'b1, 32'h200); expect_out("rd200.flush", 1'b0, 32'h10, 1'b0, 32'h200);
    step(1'b0, 1'b0, 32'h0);   expect_out("rd200.drop", 1'b0, 32'h10, 1'b1, 32'h200);
    step(1'b0, 1'b0, 32'h0);   expect_out("rd200.acc2", 1'b0, 32'h10, 1'b0, 32'h200);
    step(1'b0, 1'b0, 32'h0);   expect_out("rd200.wait", 1'b0, 32'h10, 1'b0, 32'h200);
    step(1'b0, 1'b0, 32'h0);   expect_out("rd200.dlv",  1'b1, 32'h200, 1'b1, 32'h204);
    lat_cfg = 0;

    // Redirect to an unaligned target together with hz_write.
    step(1'b1, 1'b1, 32'h103); expect_out("rd103.flush", 1'b0, 32'h200, 1'b0, 32'h100);
    step(1'b0, 1'b0, 32'h0);   expect_out("rd103.drop",  1'b0, 32'h200, 1'b1, 32'h100);
    step(1'b0, 1'b0, 32'h0);   expect_out("rd103.acc",   1'b0, 32'h200, 1'b0, 32'h100);
    step(1'b0, 1'b0, 32'h0);   expect_out("rd103.dlv",   1'b1, 32'h100, 1'b1, 32'h104);

    // Address wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC); expect_out("wrap.flush", 1'b0, 32'h100, 1'b0, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);   expect_out("wrap.drop", 1'b0, 32'h100, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);   expect_out("wrap.acc",  1'b0, 32'h100, 1'b0, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 32'h0);   expect_out("wrap.dlv",  1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);

    // Asynchronous reset while in HOLD.
    step(1'b0, 1'b0, 32'h0);   expect_out("hrst.acc",  1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);   expect_out("hrst.hold", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);   expect_out("hrst.hold2", 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1 expect_out("hrst.async", 1'b0, 32'h0, 1'b1, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    hz_write = 1'b0;
    step(1'b0, 1'b0, 32'h0);   expect_out("hrst.acc2", 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);   expect_out("hrst.dlv",  1'b1, 32'h0, 1'b1, 32'h4);

    // Randomized run against a stream-level model: delivered pcs are sequential
    // from the last redirect target, words match memory, holds freeze outputs.
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    rand_ready = 1'b1;
    exp_pc     = 32'h0;
    stall      = 0;
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      h          = ($urandom_range(0, 9) < 3);
      r          = ($urandom_range(0, 39) == 0);
      rp         = $urandom;
      lat_cfg    = $urandom_range(0, 3);
      prev_pc    = pc;
      prev_insn  = instruction;
      prev_valid = fetch_valid;
      step(h, r, rp);
      if (r) begin
        chk("rnd.rd_valid", 32'(fetch_valid), 32'(0));
        chk("rnd.rd_insn", instruction, NOP);
        chk("rnd.rd_pc", pc, prev_pc);
        exp_pc = {rp[31:2], 2'b00};
      end else if (h) begin
        chk("rnd.hz_valid", 32'(fetch_valid), 32'(prev_valid));
        chk("rnd.hz_pc", pc, prev_pc);
        chk("rnd.hz_insn", instruction, prev_insn);
      end else if (fetch_valid) begin
        chk("rnd.dlv_pc", pc, exp_pc);
        chk("rnd.dlv_insn", instruction, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        deliveries++;
        stall = 0;
      end else begin
        chk("rnd.bub_insn", instruction, NOP);
        chk("rnd.bub_pc", pc, prev_pc);
      end
      chk("rnd.addr", bus.imem_addr, exp_pc);
      if (bus.imem_req_valid) chk("rnd.one_outstanding", 32'(outstanding), 32'(0));
      if (!fetch_valid) stall++;
      if (stall > 400) begin
        chk("rnd.progress", 32'(stall), 32'(0));
        break;
      end
    end
    chk("rnd.deliveries_min", 32'(deliveries >= 100), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
